// File: rtl/vector_ror_round_sequencer.sv
// Multi-round lane-wise rotate-right sequencer: loads a block and key, applies
// in_rounds single-cycle lane RORs with the key rotating one lane per round.
module vector_ror_round_sequencer #(
    parameter int unsigned N  = 64,
    parameter int unsigned RW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_data,
    input  logic [N-1:0]  in_key,
    input  logic [RW-1:0] in_rounds,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_data,
    output logic          busy
);

    localparam int unsigned LANES = N / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [N-1:0]  data_q, data_d;
    logic [N-1:0]  key_q, key_d;
    logic [RW-1:0] cnt_q, cnt_d;

    // Rotate one 8-bit lane right by 0..7.
    function automatic logic [7:0] ror8(input logic [7:0] x, input logic [2:0] s);
        logic [15:0] w;
        w = {x, x} >> s;
        return w[7:0];
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            key_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            key_q   <= key_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and datapath: flush only redirects the state, datapath holds.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        key_d   = key_q;
        cnt_d   = cnt_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        data_d  = in_data;
                        key_d   = in_key;
                        cnt_d   = in_rounds;
                        state_d = (in_rounds != '0) ? RUN : DONE;
                    end
                end
                RUN: begin
                    for (int unsigned k = 0; k < LANES; k++) begin
                        data_d[8*k +: 8] = ror8(data_q[8*k +: 8], key_q[8*k +: 3]);
                    end
                    key_d = {key_q[7:0], key_q[N-1:8]};
                    cnt_d = cnt_q - RW'(1);
                    if (cnt_q == RW'(1)) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_data  = data_q;

endmodule
